keystream_serializer: RTL and testbench
=======================================

KEYSTREAM_SERIALIZER -- requirements
Module: keystream_serializer

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 128, width of one AES block in bits.
REQ-002 SHALL have parameter BATCH_BLOCKS, default 16, blocks per captured keystream batch.
REQ-003 SHALL have parameter XOF_TARGET, default 44, blocks to emit per session when mode=0.
REQ-004 SHALL have parameter PRF_TARGET, default 8, blocks to emit per session when mode=1.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  single-cycle pulse that opens a new session.
REQ-008 SHALL have port mode  input  1  0 = XOF, 1 = PRF; sampled only when start=1.
REQ-009 SHALL have port batch_in  input  BLOCK_SIZE*BATCH_BLOCKS  keystream batch from the parallel AES-CTR core; block k occupies bits [(k+1)*BLOCK_SIZE-1 -: BLOCK_SIZE].
REQ-010 SHALL have port batch_valid  input  1  one-cycle pulse marking batch_in as valid (core finished strobe).
REQ-011 SHALL have port din  input  BLOCK_SIZE  plaintext/ciphertext block to be XORed.
REQ-012 SHALL have port din_valid  input  1  din holds valid data.
REQ-013 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-014 SHALL have port dout  output  BLOCK_SIZE  din XOR current keystream block.
REQ-015 SHALL have port dout_valid  output  1  dout holds valid data.
REQ-016 SHALL have port dout_ready  input  1  downstream accepts dout this cycle.
REQ-017 SHALL have port dout_last  output  1  high with dout_valid on the final block of a session.
REQ-018 SHALL have port done  output  1  session complete; held until the next start or rst.
REQ-019 SHALL have port overflow  output  1  sticky: a batch arrived while the buffer was occupied.

Function
REQ-020 SHALL implement states IDLE, WAIT, EMIT and DONE.
REQ-021 start in any state SHALL: latch target (mode ? PRF_TARGET : XOF_TARGET), clear the 6-bit total counter, clear overflow, clear done, and enter WAIT on the next cycle.
REQ-022 In WAIT, batch_valid=1 SHALL copy batch_in into the internal buffer, set the 4-bit index to 0, and enter EMIT next cycle (one-cycle capture latency).
REQ-023 In EMIT: dout_valid = din_valid, din_ready = dout_ready, dout = din XOR buffer block[index]; all combinational, no added latency.
REQ-024 A transfer SHALL occur when dout_valid=1 and dout_ready=1; only then do index and total increment by 1.
REQ-025 dout_last SHALL be 1 in EMIT exactly when total == target-1.
REQ-026 On a transfer with dout_last=1, the block SHALL enter DONE and set done=1, regardless of index.
REQ-027 On a transfer with index == BATCH_BLOCKS-1 and dout_last=0, the block SHALL return to WAIT (buffer released).
REQ-028 batch_valid in EMIT or DONE SHALL be dropped without touching the buffer; in EMIT it SHALL set overflow=1.
REQ-029 start and batch_valid in the same cycle: start SHALL win; the batch is dropped and overflow is not set.
REQ-030 In IDLE, WAIT and DONE, din_ready, dout_valid and dout_last SHALL be 0 and dout SHALL be 0.
REQ-031 XOF session of 44 blocks SHALL consume 3 batches, with the third batch used for only 12 blocks; the unused 4 blocks are discarded.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, index=0, total=0, target=XOF_TARGET, buffer=0, done=0, overflow=0, din_ready=0, dout_valid=0, dout_last=0, dout=0.
REQ-033 rst asserted mid-EMIT SHALL abandon the session; after release the block stays in IDLE until start.

Verification
REQ-034 rst, start with mode=1, one batch (block k = 128'hk repeated), din=0 always valid, dout_ready=1 -> 8 transfers dout=block0..block7, dout_last on the 8th, done=1, din_ready=0 afterwards.
REQ-035 start with mode=0, three batches each supplied on WAIT -> 44 transfers, WAIT re-entered after transfers 16 and 32, dout_last on transfer 44, done=1.
REQ-036 EMIT with dout_ready toggling 1/0 every cycle, din=all-ones -> dout = ~block[index]; index advances only on cycles with dout_ready=1; no block is skipped or repeated.
REQ-037 batch_valid pulsed during EMIT -> overflow=1, subsequent dout values still come from the original buffer; next start clears overflow.
REQ-038 start and batch_valid in the same cycle from DONE -> state WAIT, overflow=0, no capture; a batch on the next cycle is captured.
REQ-039 rst pulsed after 5 PRF transfers -> all outputs 0 immediately; a new start with mode=1 yields 8 fresh transfers from block0.

Source files
------------

// File: rtl/keystream_serializer.sv
// Holds one captured AES-CTR keystream batch and XORs it block-by-block onto a
// ready/valid data stream until the session's block target is reached.
module keystream_serializer #(
  parameter int BLOCK_SIZE   = 128,
  parameter int BATCH_BLOCKS = 16,
  parameter int XOF_TARGET   = 44,
  parameter int PRF_TARGET   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             mode,
  input  logic [BLOCK_SIZE*BATCH_BLOCKS-1:0] batch_in,
  input  logic                             batch_valid,
  input  logic [BLOCK_SIZE-1:0]            din,
  input  logic                             din_valid,
  output logic                             din_ready,
  output logic [BLOCK_SIZE-1:0]            dout,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic                             dout_last,
  output logic                             done,
  output logic                             overflow
);
  localparam int IW = (BATCH_BLOCKS > 1) ? $clog2(BATCH_BLOCKS) : 1;
  localparam int TW = 6;
  localparam logic [IW-1:0] IDX_LAST = IW'(BATCH_BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, EMIT, DONE} state_t;

  state_t state_q, state_d;
  logic [BATCH_BLOCKS-1:0][BLOCK_SIZE-1:0] buf_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] total_q, target_q;
  logic emit, last, xfer;

  assign emit       = (state_q == EMIT);
  assign last       = emit && (total_q == target_q - TW'(1));
  assign xfer       = emit && din_valid && dout_ready;
  assign dout_valid = emit && din_valid;
  assign din_ready  = emit && dout_ready;
  assign dout_last  = last;
  assign dout       = emit ? (din ^ buf_q[idx_q]) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // start overrides everything, including a batch strobe in the same cycle
  always_comb begin
    state_d = state_q;
    if (start) state_d = WAIT;
    else begin
      case (state_q)
        WAIT: if (batch_valid) state_d = EMIT;
        EMIT: if (xfer) begin
          if (last)                   state_d = DONE;
          else if (idx_q == IDX_LAST) state_d = WAIT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q    <= '0;
      idx_q    <= '0;
      total_q  <= '0;
      target_q <= TW'(XOF_TARGET);
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (start) begin
      target_q <= mode ? TW'(PRF_TARGET) : TW'(XOF_TARGET);
      total_q  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state_q == WAIT && batch_valid) begin
        buf_q <= batch_in;
        idx_q <= '0;
      end
      if (emit && batch_valid) overflow <= 1'b1;
      if (xfer) begin
        idx_q   <= idx_q + IW'(1);
        total_q <= total_q + TW'(1);
        if (last) done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_keystream_serializer.sv
// Randomized scoreboard bench: driver queues expected din^keystream per session,
// monitor pops and compares on each dout handshake.
module tb_keystream_serializer;
  localparam int BS = 128;
  localparam int NB = 16;
  localparam int BW = BS * NB;

  logic clk = 0, rst = 1, start = 0, mode = 0, batch_valid = 0;
  logic [BW-1:0] batch_in = '0;
  logic [BS-1:0] din = '0, dout;
  logic din_valid = 0, din_ready, dout_valid, dout_ready = 0, dout_last, done, overflow;

  keystream_serializer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .batch_in(batch_in),
    .batch_valid(batch_valid), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [BS-1:0] d; bit last; } exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [BS-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_xfer: got %h expected none", dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("dout", dout, e.d);
        chk("dout_last", BS'(dout_last), BS'(e.last));
      end
    end
  end

  // dpat: 0 random din/blocks, 1 din=0 with block k = hex digit k, 2 din=ones
  // rmode: 0 random handshakes, 1 always valid/ready, 2 ready toggles each cycle
  task automatic run_session(input bit m, input int dpat, input int rmode,
                             input bit collide, input int ovf_at, input int rst_at);
    int T = m ? 8 : 44;
    logic [BS-1:0] blk [3][NB];
    logic [BS-1:0] dl [44];
    logic [BW-1:0] pk;
    int n = 0, b = 0, cyc = 0;
    bit ovf_done = 0, hs, feed;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < NB; k++)
        blk[i][k] = (dpat == 1) ? {32{4'(k)}} : rnd128();
    for (int i = 0; i < 44; i++)
      dl[i] = (dpat == 0) ? rnd128() : (dpat == 1) ? '0 : '1;
    for (int i = 0; i < T; i++)
      exp_q.push_back('{dl[i] ^ blk[i / NB][i % NB], i == T - 1});

    start = 1; mode = m; batch_valid = collide; batch_in = {NB{rnd128()}};
    din_valid = 0; dout_ready = 0;
    @(negedge clk); @(posedge clk); #1;
    start = 0; batch_valid = 0;

    while (n < T && !(rst_at >= 0 && n == rst_at)) begin
      feed = (n == NB * b);
      if (feed) begin
        for (int k = 0; k < NB; k++) pk[k*BS +: BS] = blk[b][k];
        batch_in = pk; batch_valid = 1;
        din_valid = 1; dout_ready = 1;
      end else begin
        if (n == ovf_at && !ovf_done) begin
          ovf_done = 1; batch_valid = 1; batch_in = {NB{rnd128()}};
        end
        din = dl[n];
        din_valid  = (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
        dout_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'(cyc % 2) : 1'($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      if (feed) begin
        chk("wait_din_ready", BS'(din_ready), '0);
        chk("wait_dout_valid", BS'(dout_valid), '0);
        if (b == 0) begin
          chk("start_ovf_clear", BS'(overflow), '0);
          chk("start_done_clear", BS'(done), '0);
        end
        b++;
      end
      hs = din_valid && din_ready;
      @(posedge clk); #1;
      batch_valid = 0;
      if (hs) n++;
      if (++cyc > 3000) begin
        checks++; errors++;
        $display("FAIL timeout: got %0d transfers expected %0d", n, T);
        break;
      end
    end

    if (rst_at >= 0 && n == rst_at) begin
      rst = 1; din_valid = 1; dout_ready = 1; din = '1;
      #1;
      chk("rst_din_ready", BS'(din_ready), '0);
      chk("rst_dout_valid", BS'(dout_valid), '0);
      chk("rst_dout", dout, '0);
      chk("rst_dout_last", BS'(dout_last), '0);
      chk("rst_done", BS'(done), '0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 0;
      for (int i = 0; i < 3; i++) begin
        batch_valid = 1; batch_in = {NB{rnd128()}};
        @(negedge clk);
        chk("idle_after_rst", BS'(din_ready), '0);
        @(posedge clk); #1;
        batch_valid = 0;
      end
      return;
    end

    din_valid = 1; dout_ready = 1;
    @(negedge clk);
    chk("end_done", BS'(done), 1);
    chk("end_din_ready", BS'(din_ready), '0);
    chk("end_dout_valid", BS'(dout_valid), '0);
    chk("end_overflow", BS'(overflow), BS'(ovf_at >= 0));
    chk("end_queue_empty", BS'(exp_q.size()), '0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    din_valid = 1; dout_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_din_ready", BS'(din_ready), '0);
    chk("reset_dout_valid", BS'(dout_valid), '0);
    chk("reset_dout", dout, '0);
    chk("reset_dout_last", BS'(dout_last), '0);
    chk("reset_done", BS'(done), '0);
    chk("reset_overflow", BS'(overflow), '0);
    rst = 0; din_valid = 0; dout_ready = 0;
    @(posedge clk); #1;

    run_session(1, 1, 1, 0, -1, -1);   // PRF, pattern blocks, din=0
    run_session(0, 0, 0, 0, -1, -1);   // XOF 44 over three batches

    batch_valid = 1; batch_in = {NB{rnd128()}};
    @(negedge clk); @(posedge clk); #1;
    batch_valid = 0;
    @(negedge clk);
    chk("done_batch_no_ovf", BS'(overflow), '0);
    chk("done_held", BS'(done), 1);
    @(posedge clk); #1;

    run_session(1, 2, 2, 0, -1, -1);   // toggling ready, din ones
    run_session(1, 0, 0, 0, 3, -1);    // batch during EMIT
    run_session(1, 0, 0, 1, -1, -1);   // start+batch collision from DONE
    run_session(1, 0, 1, 0, -1, 5);    // reset after 5 transfers
    run_session(1, 1, 1, 0, -1, -1);   // fresh session after reset
    for (int r = 0; r < 4; r++)
      run_session(1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)), -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
